// File: rtl/idma_sync_256b_rdata_collector.sv
// iDMA 256-bit R-channel collector: burst-length FIFO, beat counting, registered output.
// Optional macro IDMA_RDATA_RLAST_CHECK_EN enables the sticky rlast_err consistency check.
module idma_sync_256b_rdata_collector #(
    parameter int LEN_FIFO_DEPTH = 16,
    parameter int DATA_W         = 256
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              soft_clr,
    input  logic              ar_push,
    input  logic [3:0]        ar_len,
    input  logic              ar_last_burst,
    input  logic              rvalid,
    output logic              rready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              axi_burst_rdata_ok,
    output logic              wlen_fifo_full_s,
    output logic              len_fifo_ovf,
    output logic              rresp_err,
    output logic              rlast_err
);

    localparam int PW = $clog2(LEN_FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(LEN_FIFO_DEPTH);
    localparam logic [CW-1:0] C_AFULL = CW'(LEN_FIFO_DEPTH - 2);

    logic [4:0]        r_mem [LEN_FIFO_DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_cnt;
    logic [3:0]        r_beat_cnt;
    logic              r_out_valid;
    logic              r_out_last;
    logic [DATA_W-1:0] r_out_data;
    logic              r_ok;
    logic              r_ovf;
    logic              r_rresp_err;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic [4:0]        w_head;
    logic [3:0]        w_head_len;
    logic              w_head_lastb;
    logic              w_beat_last;
    logic              w_rready;
    logic              w_accept;
    logic              w_pop;

    assign w_full       = (r_cnt == C_DEPTH);
    assign w_empty      = (r_cnt == '0);
    assign w_push       = ar_push && !w_full;
    assign w_head       = r_mem[r_rd_ptr];
    assign w_head_len   = w_head[3:0];
    assign w_head_lastb = w_head[4];
    assign w_beat_last  = (r_beat_cnt == w_head_len);
    assign w_rready     = !w_empty && (!r_out_valid || out_ready);
    assign w_accept     = rvalid && w_rready;
    assign w_pop        = w_accept && w_beat_last;

    assign rready             = w_rready;
    assign out_valid          = r_out_valid;
    assign out_data           = r_out_data;
    assign out_last           = r_out_last;
    assign axi_burst_rdata_ok = r_ok;
    assign wlen_fifo_full_s   = (r_cnt >= C_AFULL);
    assign len_fifo_ovf       = r_ovf;
    assign rresp_err          = r_rresp_err;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < LEN_FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push && !soft_clr) begin
            r_mem[r_wr_ptr] <= {ar_last_burst, ar_len};
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else if (soft_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + CW'(1);
            end else if (!w_push && w_pop) begin
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_beat_cnt <= '0;
            r_ok       <= 1'b0;
        end else if (soft_clr) begin
            r_beat_cnt <= '0;
            r_ok       <= 1'b0;
        end else begin
            r_ok <= w_pop;
            if (w_pop) begin
                r_beat_cnt <= '0;
            end else if (w_accept) begin
                r_beat_cnt <= r_beat_cnt + 4'd1;
            end
        end
    end

    // A drain and a reload in the same cycle keep the stage full.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
        end else if (soft_clr) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_last  <= w_head_lastb && w_beat_last;
            r_out_data  <= rdata;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_ovf       <= 1'b0;
            r_rresp_err <= 1'b0;
        end else if (soft_clr) begin
            r_ovf       <= 1'b0;
            r_rresp_err <= 1'b0;
        end else begin
            if (ar_push && w_full) begin
                r_ovf <= 1'b1;
            end
            if (w_accept && (rresp != 2'b00)) begin
                r_rresp_err <= 1'b1;
            end
        end
    end

`ifdef IDMA_RDATA_RLAST_CHECK_EN
    logic r_rlast_err;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rlast_err <= 1'b0;
        end else if (soft_clr) begin
            r_rlast_err <= 1'b0;
        end else if (w_accept && (rlast != w_beat_last)) begin
            r_rlast_err <= 1'b1;
        end
    end

    assign rlast_err = r_rlast_err;
`else
    logic w_unused_rlast;

    assign w_unused_rlast = rlast;
    assign rlast_err      = 1'b0;
`endif

endmodule

// File: tb/tb_idma_sync_256b_rdata_collector.sv
// Directed bench for idma_sync_256b_rdata_collector: one task per scenario.
module tb_idma_sync_256b_rdata_collector;

    localparam int DW = 256;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          soft_clr = 1'b0;
    logic          ar_push = 1'b0;
    logic [3:0]    ar_len = '0;
    logic          ar_last_burst = 1'b0;
    logic          rvalid = 1'b0;
    logic          rready;
    logic [DW-1:0] rdata = '0;
    logic [1:0]    rresp = '0;
    logic          rlast = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          axi_burst_rdata_ok;
    logic          wlen_fifo_full_s;
    logic          len_fifo_ovf;
    logic          rresp_err;
    logic          rlast_err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [DW-1:0] q_data[$];
    logic          q_last[$];
    int            q_pulse[$];
    int            q_acc[$];

    idma_sync_256b_rdata_collector #(
        .LEN_FIFO_DEPTH(16),
        .DATA_W(DW)
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .soft_clr(soft_clr),
        .ar_push(ar_push),
        .ar_len(ar_len),
        .ar_last_burst(ar_last_burst),
        .rvalid(rvalid),
        .rready(rready),
        .rdata(rdata),
        .rresp(rresp),
        .rlast(rlast),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_last(out_last),
        .axi_burst_rdata_ok(axi_burst_rdata_ok),
        .wlen_fifo_full_s(wlen_fifo_full_s),
        .len_fifo_ovf(len_fifo_ovf),
        .rresp_err(rresp_err),
        .rlast_err(rlast_err)
    );

    always #5 aclk = ~aclk;

    // Inputs change only just after posedge, so negedge sees the values the next edge uses.
    always @(negedge aclk) begin
        if (out_valid && out_ready) begin
            q_data.push_back(out_data);
            q_last.push_back(out_last);
        end
        if (axi_burst_rdata_ok) q_pulse.push_back(cyc);
        if (rvalid && rready) q_acc.push_back(cyc);
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, need finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] mk(input int v);
        logic [31:0] w;
        w = v;
        return {8{w}};
    endfunction

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic clear_mon();
        q_data.delete();
        q_last.delete();
        q_pulse.delete();
        q_acc.delete();
    endtask

    task automatic do_clr();
        soft_clr = 1'b1;
        step();
        soft_clr = 1'b0;
    endtask

    task automatic push(input logic [3:0] len, input logic lb);
        ar_push = 1'b1;
        ar_len = len;
        ar_last_burst = lb;
        step();
        ar_push = 1'b0;
        ar_last_burst = 1'b0;
        ar_len = '0;
    endtask

    task automatic send_beats(input int n, input int base,
                              input logic [63:0] resp_mask,
                              input logic [63:0] rlast_mask);
        int k;
        int guard;
        k = 0;
        guard = 0;
        while (k < n && guard < 300) begin
            rvalid = 1'b1;
            rdata = mk(base + k);
            rresp = resp_mask[k] ? 2'd2 : 2'd0;
            rlast = rlast_mask[k];
            @(negedge aclk);
            if (rready) k++;
            step();
            guard++;
        end
        rvalid = 1'b0;
        rresp = '0;
        rlast = 1'b0;
        checks++;
        if (k !== n) begin
            errors++;
            $display("FAIL beat_timeout: accepted %0d beats, need %0d", k, n);
        end
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (2) step();
        checks++;
        if ({rready, out_valid, out_last, axi_burst_rdata_ok} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, need 0000",
                     {rready, out_valid, out_last, axi_burst_rdata_ok});
        end
        checks++;
        if ({wlen_fifo_full_s, len_fifo_ovf, rresp_err, rlast_err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b, need 0000",
                     {wlen_fifo_full_s, len_fifo_ovf, rresp_err, rlast_err});
        end
        checks++;
        if (out_data !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h, need 0", out_data);
        end
        aresetn = 1'b1;
        step();
    endtask

    task automatic test_single_burst();
        do_clr();
        clear_mon();
        push(4'd15, 1'b1);
        send_beats(16, 100, 64'h0, 64'h8000);
        repeat (4) step();
        checks++;
        if (q_data.size() !== 16) begin
            errors++;
            $display("FAIL single_count: got %0d beats, need 16", q_data.size());
        end
        for (int i = 0; i < q_data.size() && i < 16; i++) begin
            checks++;
            if (q_data[i] !== mk(100 + i) || q_last[i] !== (i == 15)) begin
                errors++;
                $display("FAIL single_beat%0d: got data %h last %b, need %h last %b",
                         i, q_data[i][31:0], q_last[i], 100 + i, (i == 15));
            end
        end
        checks++;
        if (q_pulse.size() !== 1 || q_acc.size() !== 16) begin
            errors++;
            $display("FAIL single_pulses: got %0d pulses %0d accepts, need 1 and 16",
                     q_pulse.size(), q_acc.size());
        end else begin
            checks++;
            if (q_pulse[0] !== q_acc[15] + 1) begin
                errors++;
                $display("FAIL single_pulse_time: got cycle %0d, need %0d",
                         q_pulse[0], q_acc[15] + 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_clr();
        clear_mon();
        push(4'd15, 1'b0);
        push(4'd15, 1'b0);
        push(4'd3, 1'b1);
        send_beats(36, 200, 64'h0, 64'h8_8000_8000);
        repeat (4) step();
        checks++;
        if (q_data.size() !== 36) begin
            errors++;
            $display("FAIL b2b_count: got %0d beats, need 36", q_data.size());
        end
        for (int i = 0; i < q_data.size() && i < 36; i++) begin
            checks++;
            if (q_data[i] !== mk(200 + i) || q_last[i] !== (i == 35)) begin
                errors++;
                $display("FAIL b2b_beat%0d: got data %h last %b, need %h last %b",
                         i, q_data[i][31:0], q_last[i], 200 + i, (i == 35));
            end
        end
        checks++;
        if (q_pulse.size() !== 3 || q_acc.size() !== 36) begin
            errors++;
            $display("FAIL b2b_pulses: got %0d pulses %0d accepts, need 3 and 36",
                     q_pulse.size(), q_acc.size());
        end else begin
            checks++;
            if (q_pulse[0] !== q_acc[15] + 1 || q_pulse[1] - q_pulse[0] !== 16 ||
                q_pulse[2] - q_pulse[1] !== 4) begin
                errors++;
                $display("FAIL b2b_spacing: got %0d %0d %0d, need first %0d then +16 +4",
                         q_pulse[0], q_pulse[1], q_pulse[2], q_acc[15] + 1);
            end
        end
    endtask

    task automatic test_backpressure();
        do_clr();
        clear_mon();
        push(4'd15, 1'b1);
        fork
            send_beats(16, 300, 64'h0, 64'h8000);
            begin
                repeat (6) step();
                out_ready = 1'b0;
                step();
                checks++;
                if (rready !== 1'b0 || out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_stall: got rready %b out_valid %b, need 0 1",
                             rready, out_valid);
                end
                repeat (4) step();
                out_ready = 1'b1;
            end
        join
        repeat (4) step();
        checks++;
        if (q_data.size() !== 16) begin
            errors++;
            $display("FAIL bp_count: got %0d beats, need 16", q_data.size());
        end
        for (int i = 0; i < q_data.size() && i < 16; i++) begin
            checks++;
            if (q_data[i] !== mk(300 + i) || q_last[i] !== (i == 15)) begin
                errors++;
                $display("FAIL bp_beat%0d: got data %h last %b, need %h last %b",
                         i, q_data[i][31:0], q_last[i], 300 + i, (i == 15));
            end
        end
        checks++;
        if (q_pulse.size() !== 1) begin
            errors++;
            $display("FAIL bp_pulses: got %0d, need 1", q_pulse.size());
        end
    endtask

    task automatic test_fifo_fill();
        do_clr();
        clear_mon();
        for (int i = 0; i < 13; i++) push(4'd0, 1'b0);
        checks++;
        if (wlen_fifo_full_s !== 1'b0) begin
            errors++;
            $display("FAIL fill_13: got full %b, need 0", wlen_fifo_full_s);
        end
        push(4'd0, 1'b0);
        checks++;
        if (wlen_fifo_full_s !== 1'b1) begin
            errors++;
            $display("FAIL fill_14: got full %b, need 1", wlen_fifo_full_s);
        end
        push(4'd0, 1'b0);
        push(4'd0, 1'b1);
        checks++;
        if (len_fifo_ovf !== 1'b0 || rready !== 1'b1) begin
            errors++;
            $display("FAIL fill_16: got ovf %b rready %b, need 0 1", len_fifo_ovf, rready);
        end
        push(4'd0, 1'b1);
        checks++;
        if (len_fifo_ovf !== 1'b1) begin
            errors++;
            $display("FAIL fill_17_ovf: got %b, need 1", len_fifo_ovf);
        end
        send_beats(16, 400, 64'h0, 64'hFFFF);
        repeat (4) step();
        checks++;
        if (rready !== 1'b0 || wlen_fifo_full_s !== 1'b0 || len_fifo_ovf !== 1'b1) begin
            errors++;
            $display("FAIL fill_drained: got rready %b full %b ovf %b, need 0 0 1",
                     rready, wlen_fifo_full_s, len_fifo_ovf);
        end
        checks++;
        if (q_data.size() !== 16 || q_pulse.size() !== 16) begin
            errors++;
            $display("FAIL fill_counts: got %0d beats %0d pulses, need 16 16",
                     q_data.size(), q_pulse.size());
        end
        for (int i = 0; i < q_last.size() && i < 16; i++) begin
            checks++;
            if (q_last[i] !== (i == 15)) begin
                errors++;
                $display("FAIL fill_last%0d: got %b, need %b", i, q_last[i], (i == 15));
            end
        end
    endtask

    task automatic test_error_flags();
        do_clr();
        clear_mon();
        checks++;
        if (rresp_err !== 1'b0) begin
            errors++;
            $display("FAIL err_pre: got rresp_err %b, need 0", rresp_err);
        end
        push(4'd15, 1'b1);
        send_beats(16, 500, 64'h4, 64'h8080);
        repeat (4) step();
        checks++;
        if (rresp_err !== 1'b1) begin
            errors++;
            $display("FAIL err_rresp: got %b, need 1", rresp_err);
        end
`ifdef IDMA_RDATA_RLAST_CHECK_EN
        checks++;
        if (rlast_err !== 1'b1) begin
            errors++;
            $display("FAIL err_rlast: got %b, need 1", rlast_err);
        end
`else
        checks++;
        if (rlast_err !== 1'b0) begin
            errors++;
            $display("FAIL err_rlast_tied: got %b, need 0", rlast_err);
        end
`endif
        checks++;
        if (q_pulse.size() !== 1 || q_data.size() !== 16 || q_acc.size() !== 16) begin
            errors++;
            $display("FAIL err_burst: got %0d pulses %0d beats, need 1 16",
                     q_pulse.size(), q_data.size());
        end else begin
            checks++;
            if (q_pulse[0] !== q_acc[15] + 1 || q_last[15] !== 1'b1 || q_last[7] !== 1'b0) begin
                errors++;
                $display("FAIL err_burst_end: got pulse %0d last15 %b last7 %b, need %0d 1 0",
                         q_pulse[0], q_last[15], q_last[7], q_acc[15] + 1);
            end
        end
        repeat (3) step();
        checks++;
        if (rresp_err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: got %b, need 1", rresp_err);
        end
        do_clr();
        checks++;
        if (rresp_err !== 1'b0 || rlast_err !== 1'b0) begin
            errors++;
            $display("FAIL err_clr: got %b %b, need 0 0", rresp_err, rlast_err);
        end
    endtask

    task automatic test_reset_mid_burst();
        do_clr();
        clear_mon();
        push(4'd15, 1'b1);
        send_beats(5, 600, 64'h0, 64'h0);
        aresetn = 1'b0;
        #1;
        checks++;
        if ({rready, out_valid, out_last, axi_burst_rdata_ok, wlen_fifo_full_s} !== 5'b0 ||
            out_data !== '0) begin
            errors++;
            $display("FAIL rst_mid: got ctrl %b data %h, need 00000 0",
                     {rready, out_valid, out_last, axi_burst_rdata_ok, wlen_fifo_full_s},
                     out_data[31:0]);
        end
        repeat (2) step();
        aresetn = 1'b1;
        step();
        checks++;
        if (q_pulse.size() !== 0) begin
            errors++;
            $display("FAIL rst_partial_pulse: got %0d, need 0", q_pulse.size());
        end
        clear_mon();
        push(4'd0, 1'b1);
        send_beats(1, 700, 64'h0, 64'h1);
        repeat (4) step();
        checks++;
        if (q_data.size() !== 1 || q_pulse.size() !== 1) begin
            errors++;
            $display("FAIL rst_fresh_count: got %0d beats %0d pulses, need 1 1",
                     q_data.size(), q_pulse.size());
        end else begin
            checks++;
            if (q_data[0] !== mk(700) || q_last[0] !== 1'b1) begin
                errors++;
                $display("FAIL rst_fresh_beat: got %h last %b, need %h last 1",
                         q_data[0][31:0], q_last[0], 700);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_back_to_back();
        test_backpressure();
        test_fifo_fill();
        test_error_flags();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
